// File: rtl/seg7_scan_if.sv
// Frame load handshake between the pattern producer and the seven-segment scan driver.
// The producer offers a four-digit frame; the driver accepts it whenever ready is high.
interface seg7_scan_if;
    logic        load;
    logic [31:0] seg_in;
    logic [3:0]  dig_en_in;
    logic        ready;

    modport master (
        output load,
        output seg_in,
        output dig_en_in,
        input  ready
    );

    modport slave (
        input  load,
        input  seg_in,
        input  dig_en_in,
        output ready
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// It double-buffers the frame, blanks the anodes at each digit change and swaps frames only at frame end.
module seg7_scan_driver #(
    parameter int DIG_CYCLES   = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame_done
);
    localparam int CW = (DIG_CYCLES > 2) ? $clog2(DIG_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    dig, dig_nxt;
    logic [31:0]   act_seg, act_seg_nxt, pend_seg;
    logic [3:0]    act_en, act_en_nxt, pend_en;
    logic          pend_v;
    logic          frame_end, take, drive;
    logic [3:0]    an_nxt;
    logic [7:0]    seg_nxt;

    assign bus.ready = ~pend_v;

    always_comb begin
        frame_end   = (dig == 2'd3) && (cnt == CNT_LAST);
        take        = bus.load && !pend_v;
        cnt_nxt     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        dig_nxt     = (cnt == CNT_LAST) ? dig + 2'd1 : dig;
        act_seg_nxt = act_seg;
        act_en_nxt  = act_en;
        if (frame_end && pend_v) begin
            act_seg_nxt = pend_seg;
            act_en_nxt  = pend_en;
        end else if (frame_end && take) begin
            act_seg_nxt = bus.seg_in;
            act_en_nxt  = bus.dig_en_in;
        end
        // Outputs are decoded from next state so the flops match the counters.
        drive   = (cnt_nxt >= CNT_BLANK) && act_en_nxt[dig_nxt];
        an_nxt  = drive ? ~(4'b0001 << dig_nxt) : 4'hF;
        seg_nxt = drive ? act_seg_nxt[{dig_nxt, 3'b000} +: 8] : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dig        <= 2'd0;
            act_seg    <= 32'hFFFF_FFFF;
            act_en     <= 4'h0;
            pend_seg   <= 32'hFFFF_FFFF;
            pend_en    <= 4'h0;
            pend_v     <= 1'b0;
            an         <= 4'hF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            dig        <= dig_nxt;
            act_seg    <= act_seg_nxt;
            act_en     <= act_en_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= frame_end;
            if (frame_end) begin
                pend_v <= 1'b0;
            end else if (take) begin
                pend_seg <= bus.seg_in;
                pend_en  <= bus.dig_en_in;
                pend_v   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count model of the scan.
// Literal checks pin the model at hand-computed points.
module tb_seg7_scan_driver;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FR = 4 * DC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_done;
    seg7_scan_if bus();

    seg7_scan_driver #(.DIG_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .an(an),
        .seg(seg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    // Model: t counts edges since reset release; the scan position follows from t alone.
    int         t;
    logic [7:0] m_seg[4];
    logic [3:0] m_en;
    logic [7:0] p_seg[4];
    logic [3:0] p_en;
    bit         m_pv;
    bit         m_fd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", name, got, want, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_pv = 0;
        m_fd = 0;
        m_en = 4'h0;
        p_en = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_seg[i] = 8'hFF;
            p_seg[i] = 8'hFF;
        end
    endtask

    task automatic model_step();
        bit fe;
        fe = (t % FR) == FR - 1;
        m_fd = fe;
        if (fe) begin
            if (m_pv) begin
                m_seg = p_seg;
                m_en  = p_en;
                m_pv  = 0;
            end else if (bus.load) begin
                for (int i = 0; i < 4; i++) m_seg[i] = bus.seg_in[8*i +: 8];
                m_en = bus.dig_en_in;
            end
        end else if (bus.load && !m_pv) begin
            for (int i = 0; i < 4; i++) p_seg[i] = bus.seg_in[8*i +: 8];
            p_en = bus.dig_en_in;
            m_pv = 1;
        end
        t++;
    endtask

    function automatic logic [3:0] exp_an();
        int c, d;
        c = t % DC;
        d = (t / DC) % 4;
        if (c < BC || !m_en[d]) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_seg();
        int c, d;
        c = t % DC;
        d = (t / DC) % 4;
        if (c < BC || !m_en[d]) return 8'hFF;
        return m_seg[d];
    endfunction

    always @(negedge clk) begin
        if (run) begin
            chk("an", 32'(an), 32'(exp_an()));
            chk("seg", 32'(seg), 32'(exp_seg()));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("ready", 32'(bus.ready), 32'(!m_pv));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic drive_load(input logic [31:0] s, input logic [3:0] e);
        bus.load = 1'b1;
        bus.seg_in = s;
        bus.dig_en_in = e;
        tick();
        bus.load = 1'b0;
    endtask

    logic [31:0] fa, fb, fc;
    int b;

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.seg_in = '0;
        bus.dig_en_in = '0;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        run = 1'b1;
        rst_n = 1'b1;

        // Idle after reset: dark, ready, frame_done at 32 and 64.
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 32 || k == 64) chk("fd_pulse", 32'(frame_done), 32'd1);
        end
        chk("idle_an", 32'(an), 32'hF);

        // Basic scan.
        run_to(69);
        drive_load(32'h905B_0C09, 4'hF);
        chk("ready_low", 32'(bus.ready), 32'd0);
        run_to(96);
        chk("ready_back", 32'(bus.ready), 32'd1);
        run_to(98);
        chk("d0_an", 32'(an), 32'hE);
        chk("d0_seg", 32'(seg), 32'h09);
        run_to(104);
        chk("gap_an", 32'(an), 32'hF);
        run_to(106);
        chk("d1_seg", 32'(seg), 32'h0C);
        run_to(114);
        chk("d2_an", 32'(an), 32'hB);
        run_to(122);
        chk("d3_an", 32'(an), 32'h7);
        chk("d3_seg", 32'(seg), 32'h90);

        // Disabled digits 1 and 3.
        run_to(125);
        drive_load($urandom, 4'b0101);
        run_to(139);
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_seg", 32'(seg), 32'hFF);
        run_to(147);
        chk("en2_an", 32'(an), 32'hB);

        // Second load while not ready is dropped.
        fa = $urandom;
        fb = ~fa;
        run_to(163);
        drive_load(fa, 4'hF);
        tick();
        drive_load(fb, 4'hF);
        run_to(194);
        chk("frameA_seg", 32'(seg), 32'(fa[7:0]));

        // Bypass at frame end.
        fc = $urandom;
        run_to(223);
        drive_load(fc, 4'hF);
        chk("bypass_ready", 32'(bus.ready), 32'd1);
        run_to(226);
        chk("bypass_an", 32'(an), 32'hE);
        chk("bypass_seg", 32'(seg), 32'(fc[7:0]));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.load = ($urandom_range(3) == 0);
            bus.seg_in = $urandom;
            bus.dig_en_in = 4'($urandom);
            tick();
        end
        bus.load = 1'b0;

        // Async reset during digit 2 drive with a pending frame.
        b = ((t / FR) + 1) * FR;
        run_to(b + 3);
        drive_load($urandom, 4'hF);
        run_to(b + FR + 3);
        drive_load($urandom, 4'($urandom));
        run_to(b + FR + 2 * DC + 4);
        chk("pre_rst_an", 32'(an), 32'hB);
        chk("pre_rst_ready", 32'(bus.ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("post_an", 32'(an), 32'hF);
        chk("post_ready", 32'(bus.ready), 32'd1);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
